// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed FND scan controller: double-buffered BCD word, per-digit
// blank/show slots, leading-zero and invalid-code blanking, registered outputs.
module fnd_scan_ctrl #(
    parameter int P_DIGITS    = 4,
    parameter int P_SHOW_CYC  = 50000,
    parameter int P_BLANK_CYC = 500
) (
    input  logic                  iClk,
    input  logic                  iRsn,
    input  logic                  iEnable,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [4*P_DIGITS-1:0] iBcd,
    input  logic [P_DIGITS-1:0]   iDp,
    input  logic                  iLzBlank,
    output logic [3:0]            oDec,
    output logic [P_DIGITS-1:0]   oDigit,
    output logic                  oDp,
    output logic                  oFrameDone
);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam int IW = $clog2(P_DIGITS);
    localparam int SW = (P_SHOW_CYC  > 1) ? $clog2(P_SHOW_CYC)  : 1;
    localparam int BW = (P_BLANK_CYC > 1) ? $clog2(P_BLANK_CYC) : 1;
    localparam int CW = (SW > BW) ? SW : BW;

    localparam logic [CW-1:0]       SHOW_LAST  = CW'(P_SHOW_CYC - 1);
    localparam logic [CW-1:0]       BLANK_LAST = CW'(P_BLANK_CYC - 1);
    localparam logic [IW-1:0]       IDX_LAST   = IW'(P_DIGITS - 1);
    localparam logic [P_DIGITS-1:0] DIG_ONE    = P_DIGITS'(1);

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  frame_start;

    logic [4*P_DIGITS-1:0] sh_word_q, sh_word_d, act_word_q, act_word_d;
    logic [P_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic                  sh_lz_q, sh_lz_d, act_lz_q, act_lz_d;
    logic                  full_q, full_d;
    logic                  hs;

    logic [3:0]            dec_q, dec_d;
    logic [P_DIGITS-1:0]   digit_q, digit_d;
    logic                  dp_q, dp_d;
    logic                  fd_q, fd_d;

    // A digit is dark if its code is not BCD, or if it is a leading zero.
    // Higher digits holding invalid codes count as blank, not significant.
    function automatic logic digit_lit(input logic [4*P_DIGITS-1:0] word,
                                       input logic [IW-1:0] dgt,
                                       input logic lz);
        logic [3:0] code;
        logic [3:0] hcode;
        logic       higher_sig;
        code       = word[{dgt, 2'b00} +: 4];
        higher_sig = 1'b0;
        for (int j = 0; j < P_DIGITS; j++) begin
            hcode = word[4*j +: 4];
            if (j > int'(dgt) && hcode != 4'd0 && hcode <= 4'd9)
                higher_sig = 1'b1;
        end
        return (code <= 4'd9) && !(lz && code == 4'd0 && !higher_sig && dgt != '0);
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!iEnable) begin
            state_d = ST_OFF;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
        frame_start = (state_d == ST_BLANK) && (idx_d == '0) && (state_q != ST_BLANK);
    end

    // Frame-start copy reads the old shadow before a same-cycle handshake lands.
    always_comb begin
        hs         = iValid & ~full_q;
        act_word_d = act_word_q;
        act_dp_d   = act_dp_q;
        act_lz_d   = act_lz_q;
        sh_word_d  = sh_word_q;
        sh_dp_d    = sh_dp_q;
        sh_lz_d    = sh_lz_q;
        full_d     = full_q;
        if (frame_start && full_q) begin
            act_word_d = sh_word_q;
            act_dp_d   = sh_dp_q;
            act_lz_d   = sh_lz_q;
        end
        if (hs) begin
            sh_word_d = iBcd;
            sh_dp_d   = iDp;
            sh_lz_d   = iLzBlank;
            full_d    = 1'b1;
        end else if (frame_start) begin
            full_d = 1'b0;
        end
    end

    always_comb begin
        dec_d   = act_word_d[{idx_d, 2'b00} +: 4];
        digit_d = '0;
        dp_d    = 1'b0;
        fd_d    = 1'b0;
        if (state_d == ST_SHOW) begin
            if (digit_lit(act_word_d, idx_d, act_lz_d))
                digit_d = DIG_ONE << idx_d;
            dp_d = act_dp_d[idx_d];
            fd_d = (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
        end
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state_q    <= ST_OFF;
            idx_q      <= '0;
            cnt_q      <= '0;
            sh_word_q  <= '0;
            sh_dp_q    <= '0;
            sh_lz_q    <= 1'b0;
            act_word_q <= '0;
            act_dp_q   <= '0;
            act_lz_q   <= 1'b0;
            full_q     <= 1'b0;
            dec_q      <= '0;
            digit_q    <= '0;
            dp_q       <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            sh_word_q  <= sh_word_d;
            sh_dp_q    <= sh_dp_d;
            sh_lz_q    <= sh_lz_d;
            act_word_q <= act_word_d;
            act_dp_q   <= act_dp_d;
            act_lz_q   <= act_lz_d;
            full_q     <= full_d;
            dec_q      <= dec_d;
            digit_q    <= digit_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
        end
    end

    assign oReady     = ~full_q;
    assign oDec       = dec_q;
    assign oDigit     = digit_q;
    assign oDp        = dp_q;
    assign oFrameDone = fd_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: a frame-time reference model predicts
// every cycle's outputs; a monitor compares them on the falling edge.
module tb_fnd_scan_ctrl;

    localparam int ND    = 4;
    localparam int SC    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = BC + SC;
    localparam int FRAME = ND * SLOT;
    localparam logic [10:0] RESET_OUT = 11'b1_0000_0000_00;

    logic            iClk = 1'b0;
    logic            iRsn = 1'b0;
    logic            iEnable = 1'b0;
    logic            iValid = 1'b0;
    logic            iLzBlank = 1'b0;
    logic [4*ND-1:0] iBcd = '0;
    logic [ND-1:0]   iDp = '0;
    logic            oReady;
    logic [3:0]      oDec;
    logic [ND-1:0]   oDigit;
    logic            oDp;
    logic            oFrameDone;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 iClk = ~iClk;

    fnd_scan_ctrl #(
        .P_DIGITS   (ND),
        .P_SHOW_CYC (SC),
        .P_BLANK_CYC(BC)
    ) dut (
        .iClk      (iClk),
        .iRsn      (iRsn),
        .iEnable   (iEnable),
        .iValid    (iValid),
        .oReady    (oReady),
        .iBcd      (iBcd),
        .iDp       (iDp),
        .iLzBlank  (iLzBlank),
        .oDec      (oDec),
        .oDigit    (oDigit),
        .oDp       (oDp),
        .oFrameDone(oFrameDone)
    );

    // Reference model state: position within the frame rather than an FSM.
    logic        en_m = 1'b0;
    int          t_m = 0;
    logic        full_m = 1'b0;
    logic [15:0] sh_w = '0, act_w = '0;
    logic [3:0]  sh_dp = '0, act_dp = '0;
    logic        sh_lz = 1'b0, act_lz = 1'b0;
    logic        hs_m, fs_m;
    logic [10:0] exp_q[$];

    function automatic logic lit(input logic [15:0] w, input int d, input logic lz);
        int msd;
        logic [3:0] c;
        msd = 0;
        for (int j = 0; j < ND; j++) begin
            c = w[4*j +: 4];
            if (c >= 4'd1 && c <= 4'd9) msd = j;
        end
        c = w[4*d +: 4];
        if (c > 4'd9) return 1'b0;
        if (lz && d > msd) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [10:0] model_out();
        int slot, s;
        logic show;
        logic [3:0] dig, dec;
        logic dp, fd;
        if (!en_m) return {~full_m, 4'b0000, act_w[3:0], 1'b0, 1'b0};
        slot = t_m / SLOT;
        s    = t_m % SLOT;
        show = (s >= BC);
        dec  = act_w[4*slot +: 4];
        dig  = (show && lit(act_w, slot, act_lz)) ? 4'(1 << slot) : 4'b0000;
        dp   = show && act_dp[slot];
        fd   = (t_m == FRAME - 1);
        return {~full_m, dig, dec, dp, fd};
    endfunction

    always @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            en_m = 1'b0; t_m = 0; full_m = 1'b0;
            sh_w = '0; sh_dp = '0; sh_lz = 1'b0;
            act_w = '0; act_dp = '0; act_lz = 1'b0;
            exp_q.delete();
        end else begin
            hs_m = iValid && !full_m;
            if (!iEnable) begin
                en_m = 1'b0; t_m = 0;
            end else if (!en_m) begin
                en_m = 1'b1; t_m = 0;
            end else begin
                t_m = (t_m + 1) % FRAME;
            end
            fs_m = en_m && (t_m == 0);
            if (fs_m && full_m) begin
                act_w = sh_w; act_dp = sh_dp; act_lz = sh_lz;
            end
            if (hs_m) begin
                sh_w = iBcd; sh_dp = iDp; sh_lz = iLzBlank; full_m = 1'b1;
            end else if (fs_m) begin
                full_m = 1'b0;
            end
            exp_q.push_back(model_out());
        end
    end

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got rdy=%b dig=%b dec=%h dp=%b fd=%b expected rdy=%b dig=%b dec=%h dp=%b fd=%b",
                      name, $time, got[10], got[9:6], got[5:2], got[1], got[0],
                      exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
    endtask

    logic [10:0] mon_exp;
    always @(negedge iClk) begin
        if (!iRsn) begin
            check("reset", {oReady, oDigit, oDec, oDp, oFrameDone}, RESET_OUT);
        end else if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("scan", {oReady, oDigit, oDec, oDp, oFrameDone}, mon_exp);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge iClk);
            #2;
        end
    endtask

    task automatic send(input logic [15:0] w, input logic [3:0] dp, input logic lz);
        int k;
        iValid = 1'b1; iBcd = w; iDp = dp; iLzBlank = lz;
        k = 0;
        while (!oReady && k < 4 * FRAME) begin
            tick();
            k++;
        end
        if (k >= 4 * FRAME) begin
            n_checks++;
            $display("FAIL send_timeout word=%h oReady=%b required 1", w, oReady);
        end
        tick();
        iValid = 1'b0;
    endtask

    task automatic wait_t(input int target);
        int k;
        k = 0;
        while (!(en_m && t_m == target) && k < 4 * FRAME) begin
            tick();
            k++;
        end
        if (k >= 4 * FRAME) begin
            n_checks++;
            $display("FAIL wait_timeout pos=%0d required %0d", t_m, target);
        end
    endtask

    initial begin
        tick(2);
        iRsn = 1'b1;
        tick();
        send(16'h1234, 4'b0000, 1'b0);
        iEnable = 1'b1;
        tick(2 * FRAME);

        send(16'h1111, 4'b0000, 1'b0);
        send(16'h2222, 4'b0000, 1'b0);
        tick(2 * FRAME);

        wait_t(FRAME - 1);
        send(16'h3333, 4'b0000, 1'b0);
        tick(2 * FRAME);

        send(16'h0050, 4'b0000, 1'b1);
        tick(2 * FRAME);
        send(16'h0000, 4'b0000, 1'b1);
        tick(2 * FRAME);
        send(16'h12A4, 4'b0010, 1'b0);
        tick(2 * FRAME);

        wait_t(2 * SLOT + BC + 1);
        iEnable = 1'b0;
        tick(5);
        iEnable = 1'b1;
        tick(FRAME + 3);

        wait_t(SLOT + BC + 2);
        iRsn = 1'b0;
        #1;
        check("async_reset", {oReady, oDigit, oDec, oDp, oFrameDone}, RESET_OUT);
        tick(2);
        iRsn = 1'b1;
        tick(2 * FRAME);

        repeat (600) begin
            iValid = ($urandom_range(0, 2) == 0);
            for (int d = 0; d < ND; d++)
                iBcd[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            iDp      = 4'($urandom);
            iLzBlank = 1'($urandom);
            if ($urandom_range(0, 80) == 0) iEnable = ~iEnable;
            tick();
        end
        iValid = 1'b0;
        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Time-multiplexed scan controller for the multi-digit FND (7-segment) display of the digital thermometer. It accepts a BCD display word from the measurement path over a valid/ready handshake and double-buffers it so updates apply only at frame boundaries. It cycles digit by digit, presenting each 4-bit digit code to the BCD-to-7-segment decoder alongside the one-hot digit enable. A dead-time blanking interval between digits suppresses ghosting, and leading zeros and invalid codes are blanked.

## Interface
- P_DIGITS, 4, number of digits scanned (2..8)
- P_SHOW_CYC, 50000, clock cycles a digit is lit per scan slot (≥2)
- P_BLANK_CYC, 500, clock cycles all digits are off before each slot (≥1)
- iClk  in  1  system clock; all logic on rising edge
- iRsn  in  1  asynchronous, active-low reset
- iEnable  in  1  1 = scan, 0 = display dark
- iValid  in  1  new display word offered
- oReady  out  1  shadow buffer free; transfer when iValid & oReady on a clock edge
- iBcd  in  4*P_DIGITS  digit codes; digit 0 = bits [3:0] = rightmost
- iDp  in  P_DIGITS  decimal point per digit, active-high
- iLzBlank  in  1  1 = blank leading zeros, sampled with iBcd
- oDec  out  4  digit code to the segment decoder
- oDigit  out  P_DIGITS  one-hot digit enable, active-high; all-zero = dark
- oDp  out  1  decimal point of the lit digit
- oFrameDone  out  1  one-cycle pulse at the end of the last digit's show slot

## Operation
- Buffers: shadow (word + dp + lz flag + full bit) and active. A handshake writes the shadow and sets full. oReady = ~full.
- At the start of each frame (entering BLANK for digit 0), a full shadow copies to active and full clears. Handshake and frame-start copy in the same cycle: the copy uses the old shadow contents, then the new word lands in the shadow and full stays 1.
- FSM states: OFF, BLANK, SHOW.
  - OFF: oDigit=0. Goes to BLANK for digit 0 when iEnable=1.
  - BLANK: oDigit=0. A counter runs P_BLANK_CYC cycles, then goes to SHOW.
  - SHOW: oDigit = one-hot of the digit index. Runs P_SHOW_CYC cycles, then goes to BLANK with the index incremented. The index wraps from P_DIGITS-1 to 0.
  - iEnable=0 in any state: go to OFF on the next edge and reset the index and counters to 0. The buffers keep their contents.
- Digit blanking rules (oDigit=0 during that SHOW slot; timing is unchanged):
  - code > 9;
  - leading-zero blank: lz flag set, code 0, all higher digits 0 or blank, and the digit index ≠ 0. Digit 0 is always shown.
  - oDp is still driven for a blanked digit, but has no visible effect.
- oDec = active code of the current index in all states. It is don't-care when dark, but must not be X.
- Counter widths = clog2 of the parameter values. The counters saturate-compare with `== P-1`; no overflow is possible.

## Timing
- Reset values: oDigit=0, oDec=0, oDp=0, oReady=1, oFrameDone=0, state OFF, index 0, counters 0, buffers 0.
- All outputs are registered. Output change lags the state transition by 0 cycles, because outputs are decoded from the next-state registers.
- Slot period = P_BLANK_CYC + P_SHOW_CYC cycles. Frame = P_DIGITS × slot.
- Word update latency: the handshake must precede the frame start to be displayed in that frame. Worst case is 1 frame plus 1 cycle.
- oFrameDone is high in the last SHOW cycle of digit P_DIGITS-1.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). Scanning restarts from OFF after reset is released.

## Test plan
- Reset, then iEnable=1 with P_DIGITS=4, P_BLANK_CYC=2, P_SHOW_CYC=4, word 0x1234 → oDigit sequence: 0 for 2 cycles, then 0001 with oDec=4 for 4 cycles, then 0010/3, 0100/2, 1000/1. oFrameDone pulses once every 24 cycles.
- Two handshakes within one frame: first 0x1111, then 0x2222 offered while oReady=0 → second is held off until the frame start. Display shows 1111 for a full frame, then 2222. No tearing mid-frame.
- Handshake in the exact frame-start cycle → the old shadow is displayed this frame, the new word the next frame, and oReady stays 0 for that frame.
- Word 0x0050 with iLzBlank=1 → digits 3 and 2 are dark, digits 1 and 0 show 5 and 0. Word 0x0000 → only digit 0 is lit, showing 0.
- Code 0xA in digit 1 → digit 1 slot is dark and slot timing is unchanged. iDp=4'b0010 → oDp=1 only during digit 1's slot.
- iEnable dropped mid-SHOW of digit 2 → oDigit=0 on the next edge. Re-enable restarts with BLANK of digit 0. iRsn pulsed mid-frame → all outputs are 0 asynchronously and oReady=1.
